// File: rtl/dut_ctrl_pkg.sv
// Shared widths, pin count and format codes for the per-pin waveform generator.
package dut_ctrl_pkg;

    localparam int NPINS  = 128;
    localparam int EDGE_W = 7;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        FMT_NRZ = 2'b00,
        FMT_RZ  = 2'b01,
        FMT_R1  = 2'b10,
        FMT_SBC = 2'b11
    } fmt_e;

    // Wraps to 0 once the incremented count reaches the length; lengths 0 and 1 pin the counter at 0.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic [CNT_W-1:0] len);
        logic [CNT_W:0] inc;
        inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        return (inc >= {1'b0, len}) ? '0 : inc[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dut_ctrl_pin_fmt.sv
// One pin's next drive bit: picks its counter and edge set, forms the window, applies the format.
module dut_ctrl_pin_fmt
    import dut_ctrl_pkg::*;
(
    input  logic              s,
    input  logic [1:0]        fmt,
    input  logic              tmpl,
    input  logic              cyc,
    input  logic [CNT_W-1:0]  cnt1,
    input  logic [CNT_W-1:0]  cnt2,
    input  logic [EDGE_W-1:0] le1,
    input  logic [EDGE_W-1:0] te1,
    input  logic [EDGE_W-1:0] le2,
    input  logic [EDGE_W-1:0] te2,
    output logic              drive
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] le;
    logic [CNT_W-1:0] te;
    logic             win;

    // An edge pair with le >= te gives an empty window, so the pin sits at its out-of-window level.
    always_comb begin
        cnt   = cyc ? cnt2 : cnt1;
        le    = CNT_W'(tmpl ? le2 : le1);
        te    = CNT_W'(tmpl ? te2 : te1);
        win   = (cnt >= le) && (cnt < te);
        drive = s;
        case (fmt_e'(fmt))
            FMT_NRZ: drive = s;
            FMT_RZ:  drive = win ? s : 1'b0;
            FMT_R1:  drive = win ? s : 1'b1;
            FMT_SBC: drive = win ? s : ~s;
        endcase
    end

endmodule

// File: rtl/dut_ctrl.sv
// Waveform generator top: double-buffered per-pin register files, two cycle counters
// and the registered 128-pin drive output.
module dut_ctrl
    import dut_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PERFORM_TEST,
    input  logic [NPINS-1:0]  BUS128_0,
    input  logic [NPINS-1:0]  BUS128_1,
    input  logic              SIG_LOAD,
    input  logic              SIG_TRANSFER,
    input  logic              FF_LOAD,
    input  logic              FF_TRANSFER,
    input  logic              TEMPLATE_LOAD,
    input  logic              TEMPLATE_TRANSFER,
    input  logic              CYCLE_LOAD,
    input  logic              CYCLE_TRANSFER,
    input  logic [EDGE_W-1:0] LEADING_EDGE_1,
    input  logic [EDGE_W-1:0] TRAILING_EDGE_1,
    input  logic [EDGE_W-1:0] LEADING_EDGE_2,
    input  logic [EDGE_W-1:0] TRAILING_EDGE_2,
    input  logic [CNT_W-1:0]  CYCLE_LENGTH_1,
    input  logic [CNT_W-1:0]  CYCLE_LENGTH_2,
    output logic [NPINS-1:0]  OUTPUT_SIGNALS
);

    logic [NPINS-1:0] sig_shadow;
    logic [NPINS-1:0] sig_active;
    logic [NPINS-1:0] ff_lo_shadow;
    logic [NPINS-1:0] ff_hi_shadow;
    logic [NPINS-1:0] ff_lo_active;
    logic [NPINS-1:0] ff_hi_active;
    logic [NPINS-1:0] tmpl_shadow;
    logic [NPINS-1:0] tmpl_active;
    logic [NPINS-1:0] cyc_shadow;
    logic [NPINS-1:0] cyc_active;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [NPINS-1:0] pin_drive;

    // A transfer always copies the pre-edge shadow, so load+transfer together commits the old value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sig_shadow   <= '0;
            sig_active   <= '0;
            ff_lo_shadow <= '0;
            ff_hi_shadow <= '0;
            ff_lo_active <= '0;
            ff_hi_active <= '0;
            tmpl_shadow  <= '0;
            tmpl_active  <= '0;
            cyc_shadow   <= '0;
            cyc_active   <= '0;
        end else begin
            if (SIG_LOAD)          sig_shadow   <= BUS128_0;
            if (SIG_TRANSFER)      sig_active   <= sig_shadow;
            if (FF_LOAD) begin
                ff_lo_shadow <= BUS128_0;
                ff_hi_shadow <= BUS128_1;
            end
            if (FF_TRANSFER) begin
                ff_lo_active <= ff_lo_shadow;
                ff_hi_active <= ff_hi_shadow;
            end
            if (TEMPLATE_LOAD)     tmpl_shadow  <= BUS128_0;
            if (TEMPLATE_TRANSFER) tmpl_active  <= tmpl_shadow;
            if (CYCLE_LOAD)        cyc_shadow   <= BUS128_0;
            if (CYCLE_TRANSFER)    cyc_active   <= cyc_shadow;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (PERFORM_TEST) begin
            cnt1 <= next_count(cnt1, CYCLE_LENGTH_1);
            cnt2 <= next_count(cnt2, CYCLE_LENGTH_2);
        end else begin
            cnt1 <= '0;
            cnt2 <= '0;
        end
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        dut_ctrl_pin_fmt u_pin_fmt (
            .s     (sig_active[i]),
            .fmt   ({ff_hi_active[i], ff_lo_active[i]}),
            .tmpl  (tmpl_active[i]),
            .cyc   (cyc_active[i]),
            .cnt1  (cnt1),
            .cnt2  (cnt2),
            .le1   (LEADING_EDGE_1),
            .te1   (TRAILING_EDGE_1),
            .le2   (LEADING_EDGE_2),
            .te2   (TRAILING_EDGE_2),
            .drive (pin_drive[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUTPUT_SIGNALS <= '0;
        end else begin
            OUTPUT_SIGNALS <= PERFORM_TEST ? pin_drive : '0;
        end
    end

endmodule

// File: tb/tb_dut_ctrl.sv
// Bench for dut_ctrl: directed waveform scenarios plus randomized traffic, all checked
// against a cycle-count/modulo model of the pin formats kept here.
module tb_dut_ctrl;
    import dut_ctrl_pkg::*;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             PERFORM_TEST;
    logic [NPINS-1:0] BUS128_0;
    logic [NPINS-1:0] BUS128_1;
    logic             SIG_LOAD;
    logic             SIG_TRANSFER;
    logic             FF_LOAD;
    logic             FF_TRANSFER;
    logic             TEMPLATE_LOAD;
    logic             TEMPLATE_TRANSFER;
    logic             CYCLE_LOAD;
    logic             CYCLE_TRANSFER;
    logic [6:0]       LEADING_EDGE_1;
    logic [6:0]       TRAILING_EDGE_1;
    logic [6:0]       LEADING_EDGE_2;
    logic [6:0]       TRAILING_EDGE_2;
    logic [7:0]       CYCLE_LENGTH_1;
    logic [7:0]       CYCLE_LENGTH_2;
    logic [NPINS-1:0] OUTPUT_SIGNALS;

    logic [NPINS-1:0] m_sig_sh, m_sig_act, m_ff0_sh, m_ff0_act, m_ff1_sh, m_ff1_act;
    logic [NPINS-1:0] m_tmpl_sh, m_tmpl_act, m_cyc_sh, m_cyc_act;
    logic [NPINS-1:0] exp_out;
    int               m_n;
    int               total = 0;
    int               bad = 0;

    localparam logic [NPINS-1:0] ALL_A = {32{4'hA}};
    localparam logic [NPINS-1:0] ALL_5 = {32{4'h5}};
    localparam logic [NPINS-1:0] ONES  = {NPINS{1'b1}};

    dut_ctrl u_dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .PERFORM_TEST      (PERFORM_TEST),
        .BUS128_0          (BUS128_0),
        .BUS128_1          (BUS128_1),
        .SIG_LOAD          (SIG_LOAD),
        .SIG_TRANSFER      (SIG_TRANSFER),
        .FF_LOAD           (FF_LOAD),
        .FF_TRANSFER       (FF_TRANSFER),
        .TEMPLATE_LOAD     (TEMPLATE_LOAD),
        .TEMPLATE_TRANSFER (TEMPLATE_TRANSFER),
        .CYCLE_LOAD        (CYCLE_LOAD),
        .CYCLE_TRANSFER    (CYCLE_TRANSFER),
        .LEADING_EDGE_1    (LEADING_EDGE_1),
        .TRAILING_EDGE_1   (TRAILING_EDGE_1),
        .LEADING_EDGE_2    (LEADING_EDGE_2),
        .TRAILING_EDGE_2   (TRAILING_EDGE_2),
        .CYCLE_LENGTH_1    (CYCLE_LENGTH_1),
        .CYCLE_LENGTH_2    (CYCLE_LENGTH_2),
        .OUTPUT_SIGNALS    (OUTPUT_SIGNALS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NPINS-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit in_win(input int k, input int len, input int le, input int te);
        int c;
        c = (k - 1) % len;
        return (c >= le) && (c < te);
    endfunction

    task automatic reset_model();
        {m_sig_sh, m_sig_act, m_ff0_sh, m_ff0_act, m_ff1_sh, m_ff1_act} = '0;
        {m_tmpl_sh, m_tmpl_act, m_cyc_sh, m_cyc_act} = '0;
        m_n = 0;
        exp_out = '0;
    endtask

    task automatic clear_strobes();
        {SIG_LOAD, SIG_TRANSFER, FF_LOAD, FF_TRANSFER} = '0;
        {TEMPLATE_LOAD, TEMPLATE_TRANSFER, CYCLE_LOAD, CYCLE_TRANSFER} = '0;
    endtask

    // Model one clock: output from pre-edge state (counter = edges since start mod length), then commit.
    task automatic tick();
        logic [NPINS-1:0] nxt;
        int len1, len2, c1, c2, cnt, le, te;
        bit win, s;
        len1 = int'(CYCLE_LENGTH_1);
        len2 = int'(CYCLE_LENGTH_2);
        c1 = (len1 <= 1) ? 0 : m_n % len1;
        c2 = (len2 <= 1) ? 0 : m_n % len2;
        nxt = '0;
        if (PERFORM_TEST) begin
            for (int i = 0; i < NPINS; i++) begin
                cnt = m_cyc_act[i] ? c2 : c1;
                le  = m_tmpl_act[i] ? int'(LEADING_EDGE_2)  : int'(LEADING_EDGE_1);
                te  = m_tmpl_act[i] ? int'(TRAILING_EDGE_2) : int'(TRAILING_EDGE_1);
                win = (cnt >= le) && (cnt < te);
                s   = m_sig_act[i];
                if (!m_ff1_act[i] && !m_ff0_act[i]) nxt[i] = s;
                else if (!m_ff1_act[i])              nxt[i] = win ? s : 1'b0;
                else if (!m_ff0_act[i])              nxt[i] = win ? s : 1'b1;
                else                                 nxt[i] = win ? s : !s;
            end
        end
        if (SIG_TRANSFER)      m_sig_act = m_sig_sh;
        if (SIG_LOAD)          m_sig_sh = BUS128_0;
        if (FF_TRANSFER)       begin m_ff0_act = m_ff0_sh; m_ff1_act = m_ff1_sh; end
        if (FF_LOAD)           begin m_ff0_sh = BUS128_0; m_ff1_sh = BUS128_1; end
        if (TEMPLATE_TRANSFER) m_tmpl_act = m_tmpl_sh;
        if (TEMPLATE_LOAD)     m_tmpl_sh = BUS128_0;
        if (CYCLE_TRANSFER)    m_cyc_act = m_cyc_sh;
        if (CYCLE_LOAD)        m_cyc_sh = BUS128_0;
        m_n = PERFORM_TEST ? m_n + 1 : 0;
        @(posedge CLK);
        #1;
        exp_out = nxt;
    endtask

    task automatic set_edges(input int le1, te1, cl1, le2, te2, cl2);
        LEADING_EDGE_1  = 7'(le1);
        TRAILING_EDGE_1 = 7'(te1);
        CYCLE_LENGTH_1  = 8'(cl1);
        LEADING_EDGE_2  = 7'(le2);
        TRAILING_EDGE_2 = 7'(te2);
        CYCLE_LENGTH_2  = 8'(cl2);
    endtask

    task automatic load_regs(input logic [NPINS-1:0] sig, ff0, ff1, tmpl, cyc);
        BUS128_0 = sig;  SIG_LOAD = 1'b1;      tick(); SIG_LOAD = 1'b0;
        BUS128_0 = ff0;  BUS128_1 = ff1;
        FF_LOAD = 1'b1;                        tick(); FF_LOAD = 1'b0;
        BUS128_0 = tmpl; TEMPLATE_LOAD = 1'b1; tick(); TEMPLATE_LOAD = 1'b0;
        BUS128_0 = cyc;  CYCLE_LOAD = 1'b1;    tick(); CYCLE_LOAD = 1'b0;
        {SIG_TRANSFER, FF_TRANSFER, TEMPLATE_TRANSFER, CYCLE_TRANSFER} = 4'hF;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        reset_model();
        set_edges(20, 40, 80, 40, 60, 120);
        for (int k = 0; k < 6; k++) begin
            PERFORM_TEST = 1'($urandom);
            BUS128_0 = rand128();
            BUS128_1 = rand128();
            {SIG_LOAD, SIG_TRANSFER, FF_LOAD, FF_TRANSFER} = 4'($urandom);
            {TEMPLATE_LOAD, TEMPLATE_TRANSFER, CYCLE_LOAD, CYCLE_TRANSFER} = 4'($urandom);
            @(posedge CLK);
            #1;
            total++;
            if (OUTPUT_SIGNALS !== '0) begin
                bad++;
                $display("[TB] FAIL reset_hold k=%0d got=%h exp=0", k, OUTPUT_SIGNALS);
            end
        end
        clear_strobes();
        PERFORM_TEST = 1'b0;
        RST_N = 1'b1;
        tick();
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS !== '0) begin
                bad++;
                $display("[TB] FAIL reset_empty_run k=%0d got=%h exp=0", k, OUTPUT_SIGNALS);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    task automatic test_nrz();
        logic [NPINS-1:0] want;
        want = {{31{4'hF}}, 4'hE};
        PERFORM_TEST = 1'b0;
        set_edges(20, 40, 80, 40, 60, 120);
        load_regs(want, '0, '0, '0, ALL_A);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            total++;
            if (OUTPUT_SIGNALS !== exp_out) begin
                bad++;
                $display("[TB] FAIL nrz_model k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, exp_out);
            end
            total++;
            if (OUTPUT_SIGNALS !== want) begin
                bad++;
                $display("[TB] FAIL nrz_const k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, want);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    task automatic test_sbc_even();
        bit w;
        set_edges(20, 40, 80, 40, 60, 120);
        load_regs(128'h1, ALL_5, ALL_5, '0, ALL_A);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            tick();
            w = in_win(k, 80, 20, 40);
            total++;
            if (OUTPUT_SIGNALS !== exp_out) begin
                bad++;
                $display("[TB] FAIL sbc_even_model k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, exp_out);
            end
            total++;
            if (OUTPUT_SIGNALS[0] !== w || OUTPUT_SIGNALS[2] !== !w) begin
                bad++;
                $display("[TB] FAIL sbc_even_pins k=%0d got p0=%b p2=%b exp p0=%b p2=%b",
                         k, OUTPUT_SIGNALS[0], OUTPUT_SIGNALS[2], w, !w);
            end
            total++;
            if ((OUTPUT_SIGNALS & ALL_A) !== '0) begin
                bad++;
                $display("[TB] FAIL sbc_even_odd_zero k=%0d got=%h exp=0", k, OUTPUT_SIGNALS & ALL_A);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    task automatic test_sbc_odd_cnt2();
        bit w;
        set_edges(20, 40, 80, 40, 60, 120);
        load_regs(ALL_A, ALL_A, ALL_A, '0, ALL_A);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            tick();
            w = in_win(k, 120, 20, 40);
            total++;
            if (OUTPUT_SIGNALS !== exp_out) begin
                bad++;
                $display("[TB] FAIL sbc_odd_model k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, exp_out);
            end
            total++;
            if (OUTPUT_SIGNALS[1] !== w || (OUTPUT_SIGNALS & ALL_5) !== '0) begin
                bad++;
                $display("[TB] FAIL sbc_odd_pin1 k=%0d got p1=%b even=%h exp p1=%b even=0",
                         k, OUTPUT_SIGNALS[1], OUTPUT_SIGNALS & ALL_5, w);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    task automatic test_rz_r1_empty();
        logic [NPINS-1:0] want, r;
        bit w;
        set_edges(20, 40, 80, 40, 60, 120);
        load_regs(ONES, ONES, '0, '0, '0);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            w = in_win(k, 80, 20, 40);
            want = w ? ONES : '0;
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS !== want) begin
                bad++;
                $display("[TB] FAIL rz k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, want);
            end
        end
        PERFORM_TEST = 1'b0;
        load_regs('0, '0, ONES, '0, '0);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            w = in_win(k, 80, 20, 40);
            want = w ? '0 : ONES;
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS !== want) begin
                bad++;
                $display("[TB] FAIL r1 k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, want);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
        set_edges(30, 30, 80, 30, 30, 120);
        r = rand128();
        load_regs(r, ONES, ONES, rand128(), rand128());
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS !== ~r) begin
                bad++;
                $display("[TB] FAIL empty_window k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, ~r);
            end
        end
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    task automatic test_shadow_stop();
        logic [NPINS-1:0] r1, r2, r3, r4;
        logic [NPINS-1:0] want [0:11];
        r1 = rand128(); r2 = rand128(); r3 = rand128(); r4 = rand128();
        set_edges(20, 40, 80, 40, 60, 120);
        load_regs(r1, '0, '0, '0, '0);
        want = '{r1, r1, r1, r1, r1, r1, r1, r2, r2, r2, r3, r3};
        PERFORM_TEST = 1'b1;
        for (int k = 0; k < 12; k++) begin
            clear_strobes();
            if (k == 3)  begin BUS128_0 = r2; SIG_LOAD = 1'b1; end
            if (k == 6)  SIG_TRANSFER = 1'b1;
            if (k == 8)  begin BUS128_0 = r3; SIG_LOAD = 1'b1; SIG_TRANSFER = 1'b1; end
            if (k == 9)  begin BUS128_0 = r4; SIG_LOAD = 1'b1; SIG_TRANSFER = 1'b1; end
            tick();
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS !== want[k]) begin
                bad++;
                $display("[TB] FAIL shadow_transfer k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, want[k]);
            end
        end
        clear_strobes();
        PERFORM_TEST = 1'b0;
        tick();
        load_regs(128'h1, ALL_5, ALL_5, '0, '0);
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 30; k++) tick();
        PERFORM_TEST = 1'b0;
        tick();
        total++;
        if (OUTPUT_SIGNALS !== '0 || exp_out !== '0) begin
            bad++;
            $display("[TB] FAIL stop_zero got=%h exp=0", OUTPUT_SIGNALS);
        end
        PERFORM_TEST = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            total++;
            if (OUTPUT_SIGNALS !== exp_out || OUTPUT_SIGNALS[0] !== in_win(k, 80, 20, 40)) begin
                bad++;
                $display("[TB] FAIL restart k=%0d got=%h exp=%h", k, OUTPUT_SIGNALS, exp_out);
            end
        end
        #3;
        RST_N = 1'b0;
        #1;
        total++;
        if (OUTPUT_SIGNALS !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h exp=0", OUTPUT_SIGNALS);
        end
        PERFORM_TEST = 1'b0;
        reset_model();
        #1;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int lo, hi;
        for (int it = 0; it < 6; it++) begin
            PERFORM_TEST = 1'b0;
            clear_strobes();
            tick();
            lo = (it % 3 == 0) ? 0 : 2;
            hi = (it % 3 == 0) ? 3 : 140;
            set_edges($urandom_range(0, 60), $urandom_range(0, 100), $urandom_range(lo, hi),
                      $urandom_range(0, 60), $urandom_range(0, 100), $urandom_range(lo, hi));
            load_regs(rand128(), rand128(), rand128(), rand128(), rand128());
            PERFORM_TEST = 1'b1;
            for (int k = 1; k <= 150; k++) begin
                BUS128_0 = rand128();
                BUS128_1 = rand128();
                SIG_LOAD          = ($urandom_range(0, 9) == 0);
                SIG_TRANSFER      = ($urandom_range(0, 9) == 0);
                FF_LOAD           = ($urandom_range(0, 9) == 0);
                FF_TRANSFER       = ($urandom_range(0, 9) == 0);
                TEMPLATE_LOAD     = ($urandom_range(0, 9) == 0);
                TEMPLATE_TRANSFER = ($urandom_range(0, 9) == 0);
                CYCLE_LOAD        = ($urandom_range(0, 9) == 0);
                CYCLE_TRANSFER    = ($urandom_range(0, 9) == 0);
                PERFORM_TEST      = ($urandom_range(0, 39) != 0);
                tick();
                total++;
                if (OUTPUT_SIGNALS !== exp_out) begin
                    bad++;
                    $display("[TB] FAIL random it=%0d k=%0d got=%h exp=%h", it, k, OUTPUT_SIGNALS, exp_out);
                end
            end
        end
        clear_strobes();
        PERFORM_TEST = 1'b0;
        tick();
    endtask

    initial begin
        RST_N = 1'b0;
        PERFORM_TEST = 1'b0;
        BUS128_0 = '0;
        BUS128_1 = '0;
        clear_strobes();
        test_reset();
        test_nrz();
        test_sbc_even();
        test_sbc_odd_cnt2();
        test_rz_r1_empty();
        test_shadow_stop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dut_ctrl.md
# dut_ctrl

Per-pin waveform generator for the ASIC tester's 128 DUT-facing drive signals. Host logic loads pin data, format codes, timing-template selects and cycle selects into double-buffered registers over two 128-bit buses. While a test runs, two independent cycle counters, combined with each pin's format and edge window, produce the registered OUTPUT_SIGNALS.

## Interface
- NPINS, 128, number of driven pins
- CLK  in  1  rising-edge clock; all timing is counted in CLK cycles
- RST_N  in  1  asynchronous active-low reset
- PERFORM_TEST  in  1  high = run the counters and drive the waveforms; low = idle
- BUS128_0  in  128  load data, bit i = pin i
- BUS128_1  in  128  second load data bus, used only by FF_LOAD
- SIG_LOAD / SIG_TRANSFER  in  1  shadow capture / commit to active for the signal register
- FF_LOAD / FF_TRANSFER  in  1  same for the format register
- TEMPLATE_LOAD / TEMPLATE_TRANSFER  in  1  same for the edge-template select register
- CYCLE_LOAD / CYCLE_TRANSFER  in  1  same for the cycle-length select register
- LEADING_EDGE_1, TRAILING_EDGE_1  in  7  edge set 1
- LEADING_EDGE_2, TRAILING_EDGE_2  in  7  edge set 2
- CYCLE_LENGTH_1, CYCLE_LENGTH_2  in  8  period of counter 1 and counter 2
- OUTPUT_SIGNALS  out  128  registered pin drive

## Operation
- **Double-buffered register files.** There are four: SIG (1 bit/pin), FF (2 bits/pin), TMPL (1 bit/pin), CYC (1 bit/pin). Each has a shadow copy and an active copy.
- **Load.** xx_LOAD high at an edge captures the bus into the shadow. SIG, TMPL and CYC take BUS128_0. FF takes code[i] = {BUS128_1[i], BUS128_0[i]}.
- **Transfer.** xx_TRANSFER high at an edge copies shadow to active. Only active copies affect the output. Strobes are level-sampled, so a strobe held high for N cycles repeats the action N times (idempotent).
- **Load and transfer on the same edge.** Active receives the old shadow value; shadow receives the bus.
- **Cycle counters.** cnt1 and cnt2 are 8 bits each. When PERFORM_TEST=1: cnt_k <= (cnt_k + 1 >= CYCLE_LENGTH_k) ? 0 : cnt_k + 1. A CYCLE_LENGTH of 0 or 1 pins the counter at 0. When PERFORM_TEST=0, both counters are held at 0.
- **Per-pin counter and edges.** Pin i uses cnt = CYC[i] ? cnt2 : cnt1. Its edges are LE/TE = TMPL[i] ? set 2 : set 1. Edges are zero-extended to 8 bits.
- **Window.** win = (cnt >= LE) && (cnt < TE). If LE >= TE the window is empty. Edges at or beyond the cycle length are never reached.
- **Formats**, with s = SIG[i]:
  - 00 NRZ → s
  - 01 RZ → win ? s : 0
  - 10 R1 → win ? s : 1
  - 11 SBC → win ? s : ~s
- **Idle.** When PERFORM_TEST=0, OUTPUT_SIGNALS <= 0.
- **Live transfers.** A transfer during a test takes effect immediately. The counters are not restarted.

## Timing
- **Reset.** All shadow, active, counter and output registers clear to 0 asynchronously.
- **Output latency.** OUTPUT_SIGNALS is registered. The value after edge t is the function of the active registers and counters before edge t.
- **Test start.** On the first edge with PERFORM_TEST=1, the output reflects cnt=0 and the counters advance to 1.
- **Waveform position.** Output high for window [LE, TE) appears one cycle later than the counter values.
- **Transfer latency.** An active register updated at edge t influences the output at edge t+1.
- **Test stop.** The output goes to 0 and the counters to 0 on the first edge with PERFORM_TEST=0.
- **Edge inputs.** LEADING/TRAILING/CYCLE inputs are used combinationally and are not buffered. The host must hold them stable during a test.

## Structure
- **Shared package dut_ctrl_pkg:**
  - NPINS
  - format codes FMT_NRZ=2'b00, FMT_RZ=2'b01, FMT_R1=2'b10, FMT_SBC=2'b11
  - EDGE_W=7 and CNT_W=8
- **Sub-module dut_ctrl_pin_fmt**, one instance per pin. Inputs: s, fmt, tmpl, cyc, cnt1, cnt2, both edge sets. Output: combinational next-state drive bit.
- **Top level** holds the register files, the counters and the output register.

## Test plan
- **Reset.** Hold RST_N=0 with random strobes → OUTPUT_SIGNALS=0 and all state 0. Release, then PERFORM_TEST=1 with nothing loaded → all pins 0.
- **NRZ.** Edges 20/40/80 and 40/60/120. Load and transfer SIG=FFFF…FFFE, FF=0, TMPL=0, CYC=AAAA…, then PERFORM_TEST=1 → output is constant FFFF…FFFE one cycle after start.
- **SBC on even pins.** SIG=…0001, FF buses both 5555… → pin0 is 1 for output cycles 21..40 mod 80 (0 otherwise). Pin2 is the inverse. Odd pins are constant 0.
- **SBC on odd pins with counter 2.** SIG=AAAA…, FF buses both AAAA… → pin1 is 1 only in the window [20,40) of the 120-cycle period (using cnt2). Even pins are 0.
- **RZ / R1 and empty window.** Format 01 with SIG=1 gives a pulse in the window, else 0. Format 10 with SIG=0 gives 0 in the window, else 1. With LE=TE=30, SBC pins stay at ~s.
- **Shadow isolation and stop.** Load without transfer → output unchanged. Transfer mid-test → change is visible after 1 cycle. Drop PERFORM_TEST → output 0 next edge, and the counters restart from 0 on the next start.
